affine_8tap_sum_pipe: RTL and testbench

- Downstream stage of the per-tap affine MCM blocks (tap 1..8, 1/16-pel, 8-bit samples).
- Each cycle the MCM outputs for the selected fractional phase are muxed externally into eight signed tap products.
- This block sums the eight products in a pipelined adder tree, then rounds, normalises, clips and emits the interpolated 8-bit sample.
- It carries a valid/ready handshake, an integer-position bypass and a clip-event counter.

---
 rtl/interp_pkg.sv | 65 ++++++
 rtl/interp_pipe_stage.sv | 35 +++
 rtl/affine_8tap_sum_pipe.sv | 118 +++++++++++
 tb/tb_affine_8tap_sum_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared types, widths and the round/normalise/clip helper for the affine
// 8-tap interpolation sum pipeline.
package interp_pkg;

    localparam int PW    = 15;  // signed tap-product width
    localparam int OW    = 8;   // signed output sample width
    localparam int SHIFT = 6;   // coefficient sum is 2**SHIFT = 64
    localparam int NTAP  = 8;

    typedef logic signed [PW-1:0] prod_t;
    typedef prod_t [NTAP-1:0]     prod_vec_t;

    // valid sits in the MSB so every stage payload carries its own valid bit on top.
    typedef struct packed {
        logic          valid;
        logic          bypass;
        logic [OW-1:0] int_pix;
    } tag_t;

    typedef struct packed {
        tag_t            tag;
        logic [3:0][PW:0] sum;
    } s1_t;

    typedef struct packed {
        tag_t               tag;
        logic [1:0][PW+1:0] sum;
    } s2_t;

    typedef struct packed {
        logic          clip;
        logic [OW-1:0] pix;
    } pix_t;

    typedef struct packed {
        logic valid;
        pix_t res;
    } s3_t;

    // One bit of headroom over the final sum so the rounding bias cannot overflow.
    localparam int RW = PW + 4;
    localparam logic signed [RW-1:0] PIX_MAX = RW'(2**(OW-1) - 1);
    localparam logic signed [RW-1:0] PIX_MIN = RW'(-(2**(OW-1)));
    localparam logic signed [RW-1:0] ROUND   = RW'(2**(SHIFT-1));

    function automatic pix_t round_clip(input logic [PW+2:0] sum);
        logic signed [RW-1:0] biased;
        logic signed [RW-1:0] r;
        pix_t                 res;
        biased = $signed({sum[PW+2], sum}) + ROUND;
        r      = biased >>> SHIFT;
        if (r > PIX_MAX) begin
            res.clip = 1'b1;
            res.pix  = PIX_MAX[OW-1:0];
        end else if (r < PIX_MIN) begin
            res.clip = 1'b1;
            res.pix  = PIX_MIN[OW-1:0];
        end else begin
            res.clip = 1'b0;
            res.pix  = r[OW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/interp_pipe_stage.sv
// Generic pipeline register: the MSB of the payload is the valid bit. The stage
// accepts when empty or when the downstream stage takes its current beat.
module interp_pipe_stage #(
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] up_data_i,
    input  logic          dn_ready_i,
    output logic          ready_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-2:0] payload_q;

    assign ready_o = !valid_q || dn_ready_i;
    assign data_o  = {valid_q, payload_q};

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its upstream neighbour's pre-edge value; the payload is reset
    // too because the last stage drives the block outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (ready_o) begin
            valid_q <= up_data_i[DW-1];
            if (up_data_i[DW-1]) begin
                payload_q <= up_data_i[DW-2:0];
            end
        end
    end

endmodule

// File: rtl/affine_8tap_sum_pipe.sv
// Sums eight signed tap products in a three-stage adder tree, then rounds,
// normalises and clips to an 8-bit sample, with integer bypass and clip counter.
module affine_8tap_sum_pipe
    import interp_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_frac,
    input  logic signed [OW-1:0] in_int,
    input  logic signed [PW-1:0] in_p0,
    input  logic signed [PW-1:0] in_p1,
    input  logic signed [PW-1:0] in_p2,
    input  logic signed [PW-1:0] in_p3,
    input  logic signed [PW-1:0] in_p4,
    input  logic signed [PW-1:0] in_p5,
    input  logic signed [PW-1:0] in_p6,
    input  logic signed [PW-1:0] in_p7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_pix,
    output logic                 out_clip,
    output logic [CW-1:0]        clip_cnt
);

    prod_vec_t       prods;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    s3_t             s3_d, s3_q;
    logic            s2_ready, s3_ready;
    logic [PW+2:0]   sum_fin;
    pix_t            rc;
    logic [CW-1:0]   clip_cnt_d, clip_cnt_q;

    assign prods = {in_p7, in_p6, in_p5, in_p4, in_p3, in_p2, in_p1, in_p0};

    // NOTE: every combinational output gets a full default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        s1_d.tag = '{valid: in_valid, bypass: (in_frac == 4'd0), int_pix: in_int};
        for (int k = 0; k < 4; k++) begin
            s1_d.sum[k] = {prods[2*k][PW-1], prods[2*k]}
                        + {prods[2*k+1][PW-1], prods[2*k+1]};
        end
    end

    always_comb begin
        s2_d.tag = s1_q.tag;
        for (int j = 0; j < 2; j++) begin
            s2_d.sum[j] = {s1_q.sum[2*j][PW], s1_q.sum[2*j]}
                        + {s1_q.sum[2*j+1][PW], s1_q.sum[2*j+1]};
        end
    end

    always_comb begin
        sum_fin    = {s2_q.sum[0][PW+1], s2_q.sum[0]} + {s2_q.sum[1][PW+1], s2_q.sum[1]};
        rc         = round_clip(sum_fin);
        s3_d.valid = s2_q.tag.valid;
        s3_d.res   = rc;
        if (s2_q.tag.bypass) begin
            s3_d.res = '{clip: 1'b0, pix: s2_q.tag.int_pix};
        end
    end

    // Ready ripples combinationally from out_ready back to in_ready.
    interp_pipe_stage #(.DW($bits(s1_t))) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_data_i  (s1_d),
        .dn_ready_i (s2_ready),
        .ready_o    (in_ready),
        .data_o     (s1_q)
    );

    interp_pipe_stage #(.DW($bits(s2_t))) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_data_i  (s2_d),
        .dn_ready_i (s3_ready),
        .ready_o    (s2_ready),
        .data_o     (s2_q)
    );

    interp_pipe_stage #(.DW($bits(s3_t))) u_s3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_data_i  (s3_d),
        .dn_ready_i (out_ready),
        .ready_o    (s3_ready),
        .data_o     (s3_q)
    );

    assign out_valid = s3_q.valid;
    assign out_pix   = s3_q.res.pix;
    assign out_clip  = s3_q.res.clip;

    // Counts the beat leaving S3, i.e. the old beat on a simultaneous load/drain.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (out_valid && out_ready && out_clip && (clip_cnt_q != {CW{1'b1}})) begin
            clip_cnt_d = clip_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_cnt = clip_cnt_q;

endmodule

// File: tb/tb_affine_8tap_sum_pipe.sv
// Directed bench for affine_8tap_sum_pipe; a second instance with CW=2 shares
// the stimulus so counter saturation is reachable in a few beats.
module tb_affine_8tap_sum_pipe;
    import interp_pkg::*;

    typedef logic signed [PW-1:0] prods_t [8];

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b1;
    logic [3:0]           in_frac = 4'd0;
    logic signed [OW-1:0] in_int = '0;
    prods_t               p = '{default: '0};

    logic                 in_ready, out_valid, out_clip;
    logic signed [OW-1:0] out_pix;
    logic [15:0]          clip_cnt;

    logic                 sat_in_ready, sat_out_valid, sat_out_clip;
    logic signed [OW-1:0] sat_out_pix;
    logic [1:0]           sat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    affine_8tap_sum_pipe #(.CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_frac(in_frac), .in_int(in_int),
        .in_p0(p[0]), .in_p1(p[1]), .in_p2(p[2]), .in_p3(p[3]),
        .in_p4(p[4]), .in_p5(p[5]), .in_p6(p[6]), .in_p7(p[7]),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_clip(out_clip), .clip_cnt(clip_cnt)
    );

    affine_8tap_sum_pipe #(.CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_frac(in_frac), .in_int(in_int),
        .in_p0(p[0]), .in_p1(p[1]), .in_p2(p[2]), .in_p3(p[3]),
        .in_p4(p[4]), .in_p5(p[5]), .in_p6(p[6]), .in_p7(p[7]),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_pix(sat_out_pix),
        .out_clip(sat_out_clip), .clip_cnt(sat_cnt)
    );

    function automatic prods_t one_tap(input int idx, input int val);
        prods_t r = '{default: '0};
        r[idx] = PW'(val);
        return r;
    endfunction

    function automatic prods_t all_taps(input int val);
        prods_t r;
        for (int i = 0; i < 8; i++) r[i] = PW'(val);
        return r;
    endfunction

    task automatic drive(input logic [3:0] f, input logic signed [OW-1:0] iv, input prods_t pv);
        in_frac = f;
        in_int  = iv;
        p       = pv;
    endtask

    // Sends one beat into an empty pipe and returns the result and its latency.
    task automatic single_beat(input logic [3:0] f, input logic signed [OW-1:0] iv,
                               input prods_t pv, output logic signed [OW-1:0] pix,
                               output logic clip, output int lat);
        @(negedge clk);
        drive(f, iv, pv);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        pix  = out_pix;
        clip = out_clip;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_pix !== 8'sd0) begin n_fail++; $display("FAIL reset_out_pix: got %0d want 0", out_pix); end
        n_checks++; if (out_clip !== 1'b0) begin n_fail++; $display("FAIL reset_out_clip: got %b want 0", out_clip); end
        n_checks++; if (clip_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_clip_cnt: got %0d want 0", clip_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic signed [OW-1:0] pix;
        logic                 clip;
        int                   lat;
        single_beat(4'd5, 8'sd0, one_tap(3, 6400), pix, clip, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", lat); end
        n_checks++; if (pix !== 8'sd100) begin n_fail++; $display("FAIL single_pix: got %0d want 100", pix); end
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL single_clip: got %b want 0", clip); end
    endtask

    task automatic test_rounding();
        int                   vals [3] = '{95, -33, -32};
        int                   exps [3] = '{1, -1, 0};
        logic signed [OW-1:0] pix, e;
        logic                 clip;
        int                   lat;
        for (int i = 0; i < 3; i++) begin
            single_beat(4'd9, 8'sd0, one_tap(0, vals[i]), pix, clip, lat);
            e = OW'(exps[i]);
            n_checks++; if (pix !== e) begin n_fail++; $display("FAIL round_pix[%0d]: got %0d want %0d", vals[i], pix, e); end
            n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL round_clip[%0d]: got %b want 0", vals[i], clip); end
        end
    endtask

    task automatic test_clip();
        logic signed [OW-1:0] pix;
        logic                 clip;
        int                   lat;
        single_beat(4'd15, 8'sd0, all_taps(8191), pix, clip, lat);
        n_checks++; if (pix !== 8'sd127) begin n_fail++; $display("FAIL clip_hi_pix: got %0d want 127", pix); end
        n_checks++; if (clip !== 1'b1) begin n_fail++; $display("FAIL clip_hi_flag: got %b want 1", clip); end
        n_checks++; if (clip_cnt !== 16'd1) begin n_fail++; $display("FAIL clip_hi_cnt: got %0d want 1", clip_cnt); end
        single_beat(4'd1, 8'sd0, all_taps(-8192), pix, clip, lat);
        n_checks++; if (pix !== -8'sd128) begin n_fail++; $display("FAIL clip_lo_pix: got %0d want -128", pix); end
        n_checks++; if (clip !== 1'b1) begin n_fail++; $display("FAIL clip_lo_flag: got %b want 1", clip); end
        n_checks++; if (clip_cnt !== 16'd2) begin n_fail++; $display("FAIL clip_lo_cnt: got %0d want 2", clip_cnt); end
    endtask

    task automatic test_bypass();
        logic signed [OW-1:0] pix;
        logic                 clip;
        int                   lat;
        single_beat(4'd0, -8'sd77, all_taps(8191), pix, clip, lat);
        n_checks++; if (pix !== -8'sd77) begin n_fail++; $display("FAIL bypass_pix: got %0d want -77", pix); end
        n_checks++; if (clip !== 1'b0) begin n_fail++; $display("FAIL bypass_clip: got %b want 0", clip); end
        n_checks++; if (clip_cnt !== 16'd2) begin n_fail++; $display("FAIL bypass_cnt: got %0d want 2", clip_cnt); end
    endtask

    // Six beats with out_ready low on cycles 4..7; the queue holds beats in flight.
    task automatic test_backpressure();
        int                   vals [6] = '{10, -20, 30, -40, 50, -60};
        int                   q [$];
        int                   sent = 0, got = 0, c = 0;
        logic                 exp_ready, in_acc, out_acc, seen;
        logic signed [OW-1:0] e;
        while (got < 6 && c < 40) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (sent < 6);
            if (sent < 6) drive(4'd3, 8'sd0, one_tap(3, 64 * vals[sent]));
            #1;
            exp_ready = !(q.size() == 3 && !out_ready);
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want %b", c, in_ready, exp_ready); end
            if (out_valid) begin
                e = (q.size() > 0) ? OW'(q[0]) : '0;
                n_checks++;
                if (q.size() == 0 || out_pix !== e) begin
                    n_fail++; $display("FAIL bp_pix c%0d: got %0d want %0d (queued %0d)", c, out_pix, e, q.size());
                end
            end
            in_acc  = in_valid && in_ready;
            out_acc = out_valid && out_ready;
            if (out_acc && q.size() > 0) begin
                void'(q.pop_front());
                got++;
            end
            if (in_acc) begin
                q.push_back(vals[sent]);
                sent++;
            end
            @(posedge clk);
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL bp_count: got %0d beats want 6", got); end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bp_extra_beat: got out_valid=%b want 0", seen); end
    endtask

    task automatic test_reset_midstream();
        logic seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(4'd2, 8'sd0, all_taps(8191));
            in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
        n_checks++; if (clip_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d want 0", clip_cnt); end
        n_checks++; if (out_pix !== 8'sd0) begin n_fail++; $display("FAIL async_rst_pix: got %0d want 0", out_pix); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL async_rst_stale_beat: got out_valid=%b want 0", seen); end
        n_checks++; if (clip_cnt !== 16'd0) begin n_fail++; $display("FAIL async_rst_cnt_after: got %0d want 0", clip_cnt); end
    endtask

    // Five clipped beats at full rate: one output per cycle and the CW=2 counter pins at 3.
    task automatic test_back_to_back();
        int                   q [$];
        int                   sent = 0, got = 0, c = 0, v;
        logic signed [OW-1:0] e;
        while (got < 5 && c < 8) begin
            @(negedge clk);
            in_valid = (sent < 5);
            v = (sent % 2 == 0) ? 8191 : -8192;
            if (sent < 5) drive(4'd4, 8'sd0, all_taps(v));
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, in_ready); end
            if (out_valid) begin
                e = (q.size() > 0) ? OW'(q[0]) : '0;
                n_checks++;
                if (q.size() == 0 || out_pix !== e || out_clip !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_out c%0d: got %0d/%b want %0d/1", c, out_pix, out_clip, e);
                end
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back((sent % 2 == 0) ? 127 : -128);
                sent++;
            end
            @(posedge clk);
            c++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (got != 5) begin n_fail++; $display("FAIL b2b_throughput: got %0d beats in 8 cycles want 5", got); end
        n_checks++; if (clip_cnt !== 16'd5) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 5", clip_cnt); end
        n_checks++; if (sat_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d want 3", sat_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_clip();
        test_bypass();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
